// File: rtl/stdp_pkg.sv
// Shared defaults and types for the STDP update scheduler.
package stdp_pkg;

    localparam int N_PRE_D  = 5;
    localparam int TW_D     = 8;
    localparam int WINDOW_D = 20;
    localparam int IW_D     = $clog2(N_PRE_D);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic [IW_D-1:0] idx;
        logic            ltp;
        logic [TW_D-1:0] dt;
    } upd_cmd_t;

endpackage

// File: rtl/stdp_rr_pick.sv
// Round-robin selector: first set request strictly after the pointer, wrapping back to it.
module stdp_rr_pick #(
    parameter int N_PRE = 5,
    parameter int IW    = $clog2(N_PRE)
) (
    input  logic [N_PRE-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);

    // NOTE: every output gets a default before the loops, so no latch can be inferred.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < N_PRE; i++) begin
            if (!o_found && i_req[i] && (i > int'(i_ptr))) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
        // Second pass wraps around, ending at the pointer itself.
        for (int i = 0; i < N_PRE; i++) begin
            if (!o_found && i_req[i] && (i <= int'(i_ptr))) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/stdp_update_sched.sv
// STDP update scheduler: spike-age timers, per-synapse pending LTP/LTD slots and a
// round-robin valid/ready command port towards a shared weight-update unit.
module stdp_update_sched
    import stdp_pkg::*;
#(
    parameter int N_PRE  = N_PRE_D,
    parameter int TW     = TW_D,
    parameter int WINDOW = WINDOW_D,
    parameter int IW     = $clog2(N_PRE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PRE-1:0] pre_spike,
    input  logic             post_spike,
    input  logic             enable,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [IW-1:0]    upd_idx,
    output logic             upd_ltp,
    output logic [TW-1:0]    upd_dt,
    output logic [N_PRE-1:0] pending,
    output logic [7:0]       drop_cnt,
    output logic             busy
);

    localparam logic [TW-1:0] T_MAX = '1;
    localparam logic [TW-1:0] W_LIM = TW'(WINDOW);

    logic [TW-1:0]    r_pre_t [N_PRE];
    logic [TW-1:0]    r_post_t;
    logic [N_PRE-1:0] r_pending;
    logic [N_PRE-1:0] r_slot_ltp;
    logic [TW-1:0]    r_slot_dt [N_PRE];
    logic [IW-1:0]    r_ptr;
    logic [7:0]       r_drop_cnt;
    upd_cmd_t         r_cmd;
    state_e           r_state;
    state_e           w_state_nxt;

    logic [N_PRE-1:0] w_ev;
    logic [N_PRE-1:0] w_ev_ltp;
    logic [TW-1:0]    w_ev_dt [N_PRE];
    logic [N_PRE-1:0] w_drop;
    logic [8:0]       w_drop_tot;
    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic             w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PRE; i++) r_pre_t[i] <= T_MAX;
            r_post_t <= T_MAX;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                if (pre_spike[i])            r_pre_t[i] <= '0;
                else if (r_pre_t[i] != T_MAX) r_pre_t[i] <= r_pre_t[i] + TW'(1);
            end
            if (post_spike)             r_post_t <= '0;
            else if (r_post_t != T_MAX) r_post_t <= r_post_t + TW'(1);
        end
    end

    // A coincident pre/post spike resolves to LTP with dt = 0.
    always_comb begin
        for (int i = 0; i < N_PRE; i++) begin
            w_ev[i]     = 1'b0;
            w_ev_ltp[i] = 1'b0;
            w_ev_dt[i]  = '0;
            if (post_spike && pre_spike[i]) begin
                w_ev[i]     = 1'b1;
                w_ev_ltp[i] = 1'b1;
            end else if (post_spike && (r_pre_t[i] < W_LIM)) begin
                w_ev[i]     = 1'b1;
                w_ev_ltp[i] = 1'b1;
                w_ev_dt[i]  = r_pre_t[i] + TW'(1);
            end else if (pre_spike[i] && !post_spike && (r_post_t < W_LIM)) begin
                w_ev[i]     = 1'b1;
                w_ev_dt[i]  = r_post_t + TW'(1);
            end
        end
    end

    stdp_rr_pick #(.N_PRE(N_PRE), .IW(IW)) u_pick (
        .i_req   (r_pending),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_load = enable && w_found && ((r_state == IDLE) || upd_ready);

    // A slot moving into the output register this cycle is free, so refilling it is not a drop.
    always_comb begin
        w_drop_tot = {1'b0, r_drop_cnt};
        for (int i = 0; i < N_PRE; i++) begin
            w_drop[i]  = w_ev[i] && r_pending[i] && !(w_load && (w_pick == IW'(i)));
            w_drop_tot = w_drop_tot + 9'(w_drop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                if (w_ev[i])                              r_pending[i] <= 1'b1;
                else if (w_load && (w_pick == IW'(i)))    r_pending[i] <= 1'b0;
            end
            r_drop_cnt <= (w_drop_tot > 9'd255) ? 8'hFF : w_drop_tot[7:0];
        end
    end

    // NOTE: slot payload is left unreset; it is only read while its pending bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PRE; i++) begin
            if (w_ev[i]) begin
                r_slot_ltp[i] <= w_ev_ltp[i];
                r_slot_dt[i]  <= w_ev_dt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= IW'(N_PRE - 1);
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_ptr     <= w_pick;
                r_cmd.idx <= w_pick;
                r_cmd.ltp <= r_slot_ltp[w_pick];
                r_cmd.dt  <= r_slot_dt[w_pick];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = ISSUE;
            ISSUE:   if (upd_ready && !w_load) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd_valid = (r_state == ISSUE);
        busy      = (r_state == ISSUE);
        upd_idx   = r_cmd.idx;
        upd_ltp   = r_cmd.ltp;
        upd_dt    = r_cmd.dt;
        pending   = r_pending;
        drop_cnt  = r_drop_cnt;
    end

endmodule

// File: tb/tb_stdp_update_sched.sv
// Self-checking bench: spike-time reference model feeding a scoreboard of expected commands.
module tb_stdp_update_sched;
    import stdp_pkg::*;

    localparam int N     = 5;
    localparam int TW    = 8;
    localparam int WIN   = 20;
    localparam int IW    = 3;
    localparam int NEVER = -100000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  pre_spike;
    logic          post_spike;
    logic          enable;
    logic          upd_ready;
    logic          upd_valid;
    logic [IW-1:0] upd_idx;
    logic          upd_ltp;
    logic [TW-1:0] upd_dt;
    logic [N-1:0]  pending;
    logic [7:0]    drop_cnt;
    logic          busy;

    always #5 clk = ~clk;

    stdp_update_sched #(.N_PRE(N), .TW(TW), .WINDOW(WIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .enable     (enable),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_idx    (upd_idx),
        .upd_ltp    (upd_ltp),
        .upd_dt     (upd_dt),
        .pending    (pending),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: absolute spike times, slot table, issue register.
    int       t;
    int       last_pre [N];
    int       last_post;
    bit       s_val [N];
    bit       s_ltp [N];
    int       s_dt  [N];
    bit       m_busy;
    int       m_ptr;
    upd_cmd_t m_cmd;
    int       m_drop;
    upd_cmd_t exp_q [$];

    function automatic void model_reset();
        t = 0;
        last_post = NEVER;
        for (int i = 0; i < N; i++) begin
            last_pre[i] = NEVER;
            s_val[i] = 0;
            s_ltp[i] = 0;
            s_dt[i]  = 0;
        end
        m_busy = 0;
        m_ptr  = N - 1;
        m_cmd  = '0;
        m_drop = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step();
        bit ev [N];
        bit ev_ltp [N];
        int ev_dt [N];
        int pick = -1;
        for (int i = 0; i < N; i++) begin
            ev[i] = 0; ev_ltp[i] = 0; ev_dt[i] = 0;
            if (post_spike && pre_spike[i]) begin
                ev[i] = 1; ev_ltp[i] = 1; ev_dt[i] = 0;
            end else if (post_spike && (t - last_pre[i] <= WIN)) begin
                ev[i] = 1; ev_ltp[i] = 1; ev_dt[i] = t - last_pre[i];
            end else if (pre_spike[i] && !post_spike && (t - last_post <= WIN)) begin
                ev[i] = 1; ev_ltp[i] = 0; ev_dt[i] = t - last_post;
            end
        end
        if (enable && (!m_busy || upd_ready)) begin
            for (int k = 1; k <= N; k++) begin
                int j = (m_ptr + k) % N;
                if (pick < 0 && s_val[j]) pick = j;
            end
        end
        if (pick >= 0) begin
            m_cmd.idx = IW'(pick);
            m_cmd.ltp = s_ltp[pick];
            m_cmd.dt  = TW'(s_dt[pick]);
            exp_q.push_back(m_cmd);
            s_val[pick] = 0;
            m_ptr  = pick;
            m_busy = 1;
        end else if (m_busy && upd_ready) begin
            m_busy = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (s_val[i] && m_drop < 255) m_drop++;
                s_val[i] = 1;
                s_ltp[i] = ev_ltp[i];
                s_dt[i]  = ev_dt[i];
            end
        end
        for (int i = 0; i < N; i++) if (pre_spike[i]) last_pre[i] = t;
        if (post_spike) last_post = t;
        t++;
    endfunction

    // Monitor: compares mid-cycle, pops the scoreboard on each handshake, then advances the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [N-1:0] mp;
            upd_cmd_t     e;
            for (int i = 0; i < N; i++) mp[i] = s_val[i];
            check("upd_valid", 32'(upd_valid), 32'(m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("pending", 32'(pending), 32'(mp));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (upd_valid && m_busy)
                check("payload_hold", 32'({upd_idx, upd_ltp, upd_dt}), 32'(m_cmd));
            if (upd_valid && upd_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_pop: DUT issued idx=%0d ltp=%0d dt=%0d, none expected at %0t",
                             upd_idx, upd_ltp, upd_dt, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cmd", 32'({upd_idx, upd_ltp, upd_dt}), 32'(e));
                end
            end
            model_step();
        end
    end

    task automatic drive(input logic [N-1:0] p, input logic po, input logic en, input logic rdy);
        pre_spike  = p;
        post_spike = po;
        enable     = en;
        upd_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic en, input logic rdy);
        for (int k = 0; k < n; k++) drive('0, 1'b0, en, rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        pre_spike = '0; post_spike = 1'b0; enable = 1'b0; upd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Long quiet period; a late post/pre pair must not pair with stale timers.
        idle(300, 1'b1, 1'b1);
        drive(5'b00000, 1'b1, 1'b1, 1'b1);
        idle(30, 1'b1, 1'b1);

        // pre[2] then post three cycles later: LTP dt=3.
        drive(5'b00100, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        drive(5'b00000, 1'b1, 1'b1, 1'b1);
        idle(30, 1'b1, 1'b1);

        // post then pre[4] five cycles later: LTD dt=5; 21 cycles later is out of window.
        drive(5'b00000, 1'b1, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);
        drive(5'b10000, 1'b0, 1'b1, 1'b1);
        idle(30, 1'b1, 1'b1);
        drive(5'b00000, 1'b1, 1'b1, 1'b1);
        idle(20, 1'b1, 1'b1);
        drive(5'b10000, 1'b0, 1'b1, 1'b1);
        idle(30, 1'b1, 1'b1);

        // All synapses, post four cycles later, stalled then released.
        drive(5'b11111, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);
        drive(5'b00000, 1'b1, 1'b1, 1'b0);
        idle(7, 1'b1, 1'b0);
        idle(30, 1'b1, 1'b1);

        // Coincident pre/post on synapse 1, then an overwrite while held back.
        drive(5'b00010, 1'b1, 1'b1, 1'b1);
        idle(30, 1'b1, 1'b1);
        drive(5'b00010, 1'b1, 1'b0, 1'b0);
        drive(5'b00000, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        idle(30, 1'b1, 1'b1);

        // Reset while a command is valid and stalled.
        drive(5'b00100, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);
        check("pre_rst_valid", 32'(upd_valid), 32'(m_busy));
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(upd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_idx", 32'(upd_idx), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(30, 1'b1, 1'b1);

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] p;
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(7) == 0);
            drive(p, ($urandom_range(7) == 0), ($urandom_range(7) != 0), 1'($urandom_range(1)));
        end
        idle(40, 1'b1, 1'b1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stdp_update_sched.md
Name: stdp_update_sched

Overview:
Schedules STDP weight updates for N_PRE presynaptic synapses onto one shared weight-update unit. Keeps saturating spike-age timers per synapse and for the postsynaptic neuron. Turns in-window spike pairings into LTP/LTD update commands, one pending slot per synapse. A round-robin valid/ready port issues the commands to the downstream weight datapath.

Parameters:
N_PRE, 5, number of presynaptic inputs
TW, 8, timer and dt width in bits; timers saturate at 2^TW-1
WINDOW, 20, pairing window in cycles; must satisfy 1 <= WINDOW <= 2^TW-1
IW, $clog2(N_PRE), synapse index width (derived)

Ports:
clk  in  1  clock; one clock domain
rst_n  in  1  asynchronous active-low reset
pre_spike  in  N_PRE  presynaptic spike pulses, sampled each cycle
post_spike  in  1  postsynaptic spike pulse
enable  in  1  allows new commands to be issued; timers and event capture always run
upd_valid  out  1  update command valid
upd_ready  in  1  downstream accepts the command
upd_idx  out  IW  synapse index of the command
upd_ltp  out  1  1 = potentiate (LTP), 0 = depress (LTD)
upd_dt  out  TW  spike-time difference magnitude
pending  out  N_PRE  per-synapse pending-slot flags
drop_cnt  out  8  count of overwritten pending updates, saturating
busy  out  1  high when state is ISSUE

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all timers = 2^TW-1 ("never spiked"); pending = 0; RR pointer = N_PRE-1; state = IDLE.
  - upd_valid = 0, upd_idx = 0, upd_ltp = 0, upd_dt = 0, drop_cnt = 0, busy = 0.
  - Assertion mid-transaction drops the command immediately; no handshake completion is required.
- Timers:
  - pre_t[i] <= 0 on pre_spike[i], else saturating +1; post_t behaves the same on post_spike.
  - No wrap-around.
- Event capture in cycle t, using register values before the update:
  - post_spike=1: for each i with pre_spike[i]=0 and pre_t[i] < WINDOW, load slot i with LTP, dt = pre_t[i]+1. A pre spike in cycle s gives dt = t-s.
  - pre_spike[i]=1 and post_spike=0: if post_t < WINDOW, load slot i with LTD, dt = post_t+1.
  - pre_spike[i]=1 and post_spike=1 in the same cycle: load slot i with LTP, dt = 0 (tie resolves to LTP).
  - Timer at saturation, or >= WINDOW: no command is generated.
- Pending slots:
  - One slot per synapse holding {ltp, dt}. A captured event sets pending[i] at edge t+1.
  - A new event for a slot that is already pending overwrites it (newest wins); drop_cnt adds one per overwritten slot, multiple in one cycle add their total, saturating at 255.
  - A slot being loaded into the output register in the same cycle as a new event for it counts as freed: the new event sets pending with no drop.
- FSM, states IDLE and ISSUE:
  - IDLE: if enable and |pending, the RR pick (first pending index after the pointer, wrapping) loads upd_idx/upd_ltp/upd_dt. pending[pick] clears, pointer = pick, state goes to ISSUE, and upd_valid=1 from the next cycle.
  - ISSUE: outputs stay stable while upd_ready=0. On upd_valid & upd_ready: if enable and |pending (after that cycle's updates), load the next pick back-to-back (throughput 1 per cycle) and stay in ISSUE; else go to IDLE with upd_valid=0.
  - enable=0 during ISSUE: the current command still completes; no new command is loaded; pending slots are retained.
- No combinational path from upd_ready to upd_valid or the payload. All outputs are registered.

Decomposition:
- Package stdp_pkg: default N_PRE/TW/WINDOW localparams, the state enum {IDLE, ISSUE}, and an update-command struct {idx, ltp, dt}.
- One sub-module, stdp_rr_pick: combinational round-robin first-set-after-pointer selector, N_PRE parameterised, outputs found/index.

Test Plan:
- Reset, then no spikes for 300 cycles -> pending=0, upd_valid never rises, timers saturate at 255.
- pre_spike[2] at cycle 10, post_spike at cycle 13, upd_ready=1 -> one command idx=2, ltp=1, dt=3; upd_valid rises at cycle 15 and lasts one cycle.
- post_spike at 10, pre_spike[4] at 15 -> idx=4, ltp=0, dt=5. Same stimulus with pre at 31 (WINDOW=20) -> no command.
- pre_spike=5'b11111 at 0, post_spike at 4, upd_ready held 0 for 5 cycles then 1 -> five LTP commands with dt=4, issued back-to-back in order 0,1,2,3,4; payload stable while stalled.
- Same pre/post cycle on synapse 1 -> idx=1, ltp=1, dt=0. Second event on synapse 1 while stalled -> drop_cnt=1, and the issued dt is from the newer event.
- rst_n pulled low while upd_valid=1 and stalled -> upd_valid=0 immediately, pending=0, drop_cnt=0.
